// File: rtl/fifo_rd_streamer_if.sv
// fifo_rd_streamer_if: groups the FIFO read port and the valid/ready output
// stream of the read-side streamer.
// master = streamer side, slave = FIFO/consumer side.
// Optional macro FIFO_RD_PARITY_EN adds the out_parity sideband.
interface fifo_rd_streamer_if #(
    parameter int data_width = 32
);
    logic                  fifo_empty;
    logic [data_width-1:0] fifo_rd_data;
    logic                  fifo_rd_en;
    logic [data_width-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
`ifdef FIFO_RD_PARITY_EN
    logic                  out_parity;
`endif

    modport master (
        input  fifo_empty, fifo_rd_data, out_ready,
        output fifo_rd_en, out_data, out_valid
`ifdef FIFO_RD_PARITY_EN
        , output out_parity
`endif
    );

    modport slave (
        output fifo_empty, fifo_rd_data, out_ready,
        input  fifo_rd_en, out_data, out_valid
`ifdef FIFO_RD_PARITY_EN
        , input out_parity
`endif
    );
endinterface

// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: read-side engine of the async FIFO (read clock domain).
// Pops words from the FIFO and re-presents them on a valid/ready stream.
// A 2-entry buffer absorbs the FIFO's 1-cycle read latency so the stream
// sustains 1 word/clock without losing or duplicating words under backpressure.
// Optional macro FIFO_RD_PARITY_EN: stores even parity per buffered word and
// drives it on out_parity alongside out_data.
module fifo_rd_streamer #(
    parameter int data_width = 32,
    parameter int cnt_width  = 16
) (
    input  logic                 rd_clk,
    input  logic                 rst,
    input  logic                 enable,
    fifo_rd_streamer_if.master   bus,
    output logic                 busy,
    output logic [cnt_width-1:0] word_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [1:0]            r_count;
    logic                  r_inflight;
    logic                  r_valid;
    logic [data_width-1:0] r_d0;
    logic [data_width-1:0] r_d1;
    logic [cnt_width-1:0]  r_word_cnt;
    logic                  w_pop;
    logic                  w_rd_en;
    logic [2:0]            w_occ;

    // A word leaves the buffer whenever the head is offered and accepted.
    assign w_pop = r_valid & bus.out_ready;

    // Occupancy next cycle: current words, plus the one arriving, minus the one leaving.
    assign w_occ = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};

    // Next-state and fetch request; fetch only while streaming and the buffer has room.
    always_comb begin
        w_state_nxt = r_state;
        w_rd_en     = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable) w_state_nxt = STREAM;
            end
            STREAM: begin
                w_rd_en = enable & ~bus.fifo_empty & (w_occ < 3'd2);
                if (!enable) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (enable)
                    w_state_nxt = STREAM;
                else if (r_count == 2'd0 && !r_inflight)
                    w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    // Control: occupancy, in-flight marker, valid flag and delivered-word counter.
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            r_count    <= 2'd0;
            r_inflight <= 1'b0;
            r_valid    <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            r_count    <= w_occ[1:0];
            r_inflight <= w_rd_en;
            r_valid    <= (w_occ != 3'd0);
            if (w_pop) r_word_cnt <= r_word_cnt + cnt_width'(1);
        end
    end

    // Buffer storage: the arriving word lands behind whatever remains after a pop.
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            r_d0 <= '0;
            r_d1 <= '0;
        end else if (r_inflight) begin
            if (w_pop) begin
                if (r_count == 2'd2) begin
                    r_d0 <= r_d1;
                    r_d1 <= bus.fifo_rd_data;
                end else begin
                    r_d0 <= bus.fifo_rd_data;
                end
            end else if (r_count == 2'd0) begin
                r_d0 <= bus.fifo_rd_data;
            end else begin
                r_d1 <= bus.fifo_rd_data;
            end
        end else if (w_pop) begin
            r_d0 <= r_d1;
        end
    end

`ifdef FIFO_RD_PARITY_EN
    logic r_p0;
    logic r_p1;

    function automatic logic f_parity(input logic [data_width-1:0] d);
        return ^d;
    endfunction

    // Parity entries move in lockstep with the data entries.
    always_ff @(posedge rd_clk or posedge rst) begin
        if (rst) begin
            r_p0 <= 1'b0;
            r_p1 <= 1'b0;
        end else if (r_inflight) begin
            if (w_pop) begin
                if (r_count == 2'd2) begin
                    r_p0 <= r_p1;
                    r_p1 <= f_parity(bus.fifo_rd_data);
                end else begin
                    r_p0 <= f_parity(bus.fifo_rd_data);
                end
            end else if (r_count == 2'd0) begin
                r_p0 <= f_parity(bus.fifo_rd_data);
            end else begin
                r_p1 <= f_parity(bus.fifo_rd_data);
            end
        end else if (w_pop) begin
            r_p0 <= r_p1;
        end
    end

    assign bus.out_parity = r_p0;
`endif

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.out_data   = r_d0;
    assign bus.out_valid  = r_valid;
    assign busy           = (r_state != IDLE);
    assign word_cnt       = r_word_cnt;

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// tb_fifo_rd_streamer: directed bench for fifo_rd_streamer with a small
// behavioural FIFO (1-cycle read latency) and a stream monitor.
module tb_fifo_rd_streamer;
    localparam int DW = 32;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          busy;
    logic [CW-1:0] word_cnt;

    fifo_rd_streamer_if #(.data_width(DW)) bus();

    fifo_rd_streamer #(.data_width(DW), .cnt_width(CW)) dut (
        .rd_clk   (clk),
        .rst      (rst),
        .enable   (enable),
        .bus      (bus),
        .busy     (busy),
        .word_cnt (word_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural FIFO: storage written by the stimulus, read pointer owned by the model.
    logic [DW-1:0] mem [0:127];
    int wr_ptr = 0;
    int rd_ptr = 0;
    int m_nxt;
    int n_pops = 0;
    int bad_rd = 0;
    int fl_tok = 0;
    int fl_seen = 0;

    // FIFO model: pop on rd_en with data one cycle later; flush on request.
    always @(posedge clk) begin
        m_nxt = rd_ptr;
        if (fl_tok != fl_seen) begin
            m_nxt = wr_ptr;
            fl_seen <= fl_tok;
        end else if (bus.fifo_rd_en === 1'b1) begin
            if (bus.fifo_empty) begin
                bad_rd <= bad_rd + 1;
            end else begin
                bus.fifo_rd_data <= mem[m_nxt];
                m_nxt = m_nxt + 1;
                n_pops <= n_pops + 1;
            end
        end
        rd_ptr <= m_nxt;
        bus.fifo_empty <= (m_nxt == wr_ptr);
    end

    // Stream monitor, sampled mid-cycle.
    logic [DW-1:0] got [$];
    int del_cyc [$];
    int cyc = 0;
    int n_rd = 0;
    int n_vld = 0;
    int unstable = 0;
    logic prev_v = 1'b0;
    logic prev_r = 1'b0;
    logic [DW-1:0] prev_d = '0;

    // Record accepted words, rd_en/valid cycles and hold-stability violations.
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (bus.fifo_rd_en === 1'b1) n_rd = n_rd + 1;
        if (bus.out_valid === 1'b1) n_vld = n_vld + 1;
        if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            got.push_back(bus.out_data);
            del_cyc.push_back(cyc);
        end
        if (prev_v && !prev_r && (bus.out_valid !== 1'b1 || bus.out_data !== prev_d))
            unstable = unstable + 1;
        prev_v = (bus.out_valid === 1'b1);
        prev_r = (bus.out_ready === 1'b1);
        prev_d = bus.out_data;
    end

    int b_rd, b_vld, b_got, b_pop, b_bad, b_uns;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DW-1:0] w);
        mem[wr_ptr] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic snap();
        b_rd = n_rd; b_vld = n_vld; b_got = got.size();
        b_pop = n_pops; b_bad = bad_rd; b_uns = unstable;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; bus.out_ready = 1'b0;
        step(2);
        rst = 1'b0;
        step(1);
        snap();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; bus.out_ready = 1'b0;
        step(2);
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (bus.out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", bus.out_data); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (word_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", word_cnt); end
        n_cmp++; if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %b want 0", bus.fifo_rd_en); end
        rst = 1'b0;
        step(2);
        n_cmp++; if (bus.out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: valid %b busy %b want 0 0", bus.out_valid, busy); end
    endtask

    task automatic test_single();
        do_reset();
        push(32'h11);
        bus.out_ready = 1'b1; enable = 1'b1;
        step(10);
        n_cmp++; if (n_rd - b_rd !== 1) begin n_fail++; $display("FAIL single_rd_pulses: got %0d want 1", n_rd - b_rd); end
        n_cmp++; if (n_vld - b_vld !== 1) begin n_fail++; $display("FAIL single_valid_cycles: got %0d want 1", n_vld - b_vld); end
        n_cmp++; if (got.size() - b_got !== 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", got.size() - b_got); end
        else begin
            n_cmp++; if (got[b_got] !== 32'h11) begin n_fail++; $display("FAIL single_data: got %h want 11", got[b_got]); end
        end
        n_cmp++; if (word_cnt !== 16'd1) begin n_fail++; $display("FAIL single_word_cnt: got %0d want 1", word_cnt); end
        n_cmp++; if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL single_rd_en_idle: got %b want 0", bus.fifo_rd_en); end
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_stream: got %b want 1", busy); end
        enable = 1'b0;
        step(3);
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_idle: got %b want 0", busy); end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 15; i++) push(DW'(i));
        bus.out_ready = 1'b1; enable = 1'b1;
        step(40);
        n_cmp++; if (got.size() - b_got !== 15) begin n_fail++; $display("FAIL stream_count: got %0d want 15", got.size() - b_got); end
        else begin
            for (int i = 0; i < 15; i++) begin
                n_cmp++; if (got[b_got+i] !== DW'(i)) begin n_fail++; $display("FAIL stream_word%0d: got %h want %h", i, got[b_got+i], i); end
            end
            n_cmp++; if (del_cyc[b_got+14] - del_cyc[b_got] !== 14) begin n_fail++; $display("FAIL stream_gapless: span %0d want 14", del_cyc[b_got+14] - del_cyc[b_got]); end
        end
        n_cmp++; if (bad_rd - b_bad !== 0) begin n_fail++; $display("FAIL stream_rd_when_empty: got %0d want 0", bad_rd - b_bad); end
        n_cmp++; if (word_cnt !== 16'd15) begin n_fail++; $display("FAIL stream_word_cnt: got %0d want 15", word_cnt); end
        enable = 1'b0;
        step(3);
    endtask

    task automatic test_backpressure();
        do_reset();
        push(32'h55); push(32'hEE); push(32'hAA);
        bus.out_ready = 1'b0; enable = 1'b1;
        step(12);
        n_cmp++; if (n_pops - b_pop !== 2) begin n_fail++; $display("FAIL bp_pops: got %0d want 2", n_pops - b_pop); end
        n_cmp++; if (bus.fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_rd_en: got %b want 0", bus.fifo_rd_en); end
        n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h55) begin n_fail++; $display("FAIL bp_head: valid %b data %h want 1 55", bus.out_valid, bus.out_data); end
        n_cmp++; if (unstable - b_uns !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d changes want 0", unstable - b_uns); end
        bus.out_ready = 1'b1;
        step(10);
        n_cmp++; if (got.size() - b_got !== 3) begin n_fail++; $display("FAIL bp_count: got %0d want 3", got.size() - b_got); end
        else begin
            n_cmp++; if (got[b_got] !== 32'h55 || got[b_got+1] !== 32'hEE || got[b_got+2] !== 32'hAA) begin
                n_fail++; $display("FAIL bp_order: got %h %h %h want 55 ee aa", got[b_got], got[b_got+1], got[b_got+2]); end
            n_cmp++; if (del_cyc[b_got+2] - del_cyc[b_got] !== 2) begin n_fail++; $display("FAIL bp_gapless: span %0d want 2", del_cyc[b_got+2] - del_cyc[b_got]); end
        end
        n_cmp++; if (word_cnt !== 16'd3) begin n_fail++; $display("FAIL bp_word_cnt: got %0d want 3", word_cnt); end
        enable = 1'b0;
        step(3);
    endtask

    task automatic test_drain();
        int waited;
        do_reset();
        for (int i = 0; i < 15; i++) push(DW'(i));
        bus.out_ready = 1'b1; enable = 1'b1;
        waited = 0;
        while (n_pops - b_pop < 5 && waited < 50) begin
            step(1);
            waited++;
        end
        n_cmp++; if (n_pops - b_pop < 5) begin n_fail++; $display("FAIL drain_wait: got %0d pops want 5 within 50 cycles", n_pops - b_pop); end
        enable = 1'b0;
        step(1);
        n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL drain_busy: got %b want 1", busy); end
        step(20);
        n_cmp++; if (n_pops - b_pop !== 5) begin n_fail++; $display("FAIL drain_pops: got %0d want 5", n_pops - b_pop); end
        n_cmp++; if (got.size() - b_got !== 5) begin n_fail++; $display("FAIL drain_count: got %0d want 5", got.size() - b_got); end
        else begin
            for (int i = 0; i < 5; i++) begin
                n_cmp++; if (got[b_got+i] !== DW'(i)) begin n_fail++; $display("FAIL drain_word%0d: got %h want %h", i, got[b_got+i], i); end
            end
        end
        n_cmp++; if (busy !== 1'b0 || bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_idle: busy %b valid %b want 0 0", busy, bus.out_valid); end
        n_cmp++; if (wr_ptr - rd_ptr !== 10) begin n_fail++; $display("FAIL drain_left_in_fifo: got %0d want 10", wr_ptr - rd_ptr); end
        n_cmp++; if (word_cnt !== 16'd5) begin n_fail++; $display("FAIL drain_word_cnt: got %0d want 5", word_cnt); end
        fl_tok = fl_tok + 1;
        step(2);
    endtask

    task automatic test_reset_mid();
        do_reset();
        push(32'hA0); push(32'hA1); push(32'hA2); push(32'hA3);
        bus.out_ready = 1'b0; enable = 1'b1;
        step(6);
        bus.out_ready = 1'b1;
        step(1);
        bus.out_ready = 1'b0;
        step(4);
        n_cmp++; if (word_cnt !== 16'd1 || bus.out_valid !== 1'b1 || bus.out_data !== 32'hA1) begin
            n_fail++; $display("FAIL rmid_pre: cnt %0d valid %b data %h want 1 1 a1", word_cnt, bus.out_valid, bus.out_data); end
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b want 0", bus.out_valid); end
        n_cmp++; if (word_cnt !== 16'd0) begin n_fail++; $display("FAIL rmid_word_cnt: got %0d want 0", word_cnt); end
        n_cmp++; if (bus.out_data !== 32'h0 || busy !== 1'b0) begin n_fail++; $display("FAIL rmid_data_busy: data %h busy %b want 0 0", bus.out_data, busy); end
        fl_tok = fl_tok + 1;
        step(2);
        rst = 1'b0; bus.out_ready = 1'b1; enable = 1'b1;
        snap();
        step(10);
        n_cmp++; if (n_vld - b_vld !== 0) begin n_fail++; $display("FAIL rmid_spurious_valid: got %0d cycles want 0", n_vld - b_vld); end
        n_cmp++; if (n_rd - b_rd !== 0) begin n_fail++; $display("FAIL rmid_spurious_rd: got %0d cycles want 0", n_rd - b_rd); end
        enable = 1'b0;
        step(2);
    endtask

`ifdef FIFO_RD_PARITY_EN
    task automatic test_parity();
        do_reset();
        push(32'hFF); push(32'h01);
        bus.out_ready = 1'b0; enable = 1'b1;
        step(6);
        n_cmp++; if (bus.out_data !== 32'hFF || bus.out_parity !== 1'b0) begin n_fail++; $display("FAIL parity_ff: data %h par %b want ff 0", bus.out_data, bus.out_parity); end
        bus.out_ready = 1'b1;
        step(1);
        n_cmp++; if (bus.out_data !== 32'h01 || bus.out_parity !== 1'b1) begin n_fail++; $display("FAIL parity_01: data %h par %b want 01 1", bus.out_data, bus.out_parity); end
        step(3);
        enable = 1'b0;
        step(3);
    endtask
`endif

    initial begin
        rst = 1'b1; enable = 1'b0; bus.out_ready = 1'b0;
        test_reset();
        test_single();
        test_stream();
        test_backpressure();
        test_drain();
        test_reset_mid();
`ifdef FIFO_RD_PARITY_EN
        test_parity();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end
endmodule

// File: doc/fifo_rd_streamer.md
Name: fifo_rd_streamer

Overview:
- Read-side engine for the 16-location asynchronous FIFO, running in the FIFO read clock domain.
- Pops words via rd_en/rd_data/empty and re-presents them on a valid/ready stream toward the consumer.
- Owns the FIFO's 1-cycle read latency with a 2-entry output buffer, so sustained throughput is 1 word/clock with no lost or duplicated words under backpressure.
- Adds run/stop control, an explicit drain state and a pop counter.

Parameters:
- data_width, 32, FIFO and stream word width.
- cnt_width, 16, width of the delivered-word counter.

Ports:
- rd_clk  input  1  read-domain clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- enable  input  1  1 = fetch from FIFO; 0 = stop fetching and drain the buffer.
- fifo_empty  input  1  FIFO empty flag (rd_clk domain).
- fifo_rd_data  input  data_width  FIFO read data, valid 1 cycle after an accepted rd_en.
- fifo_rd_en  output  1  FIFO pop request.
- out_data  output  data_width  stream data (head of buffer).
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  consumer accepts the word this cycle.
- busy  output  1  state != IDLE.
- word_cnt  output  cnt_width  words delivered (out_valid & out_ready) since reset.

Behaviour:
- Reset (async, rst=1): fifo_rd_en=0, out_valid=0, out_data=0, busy=0, word_cnt=0, buffer count=0, inflight=0, state=IDLE.
- Read latency: fifo_rd_en=1 at edge N with fifo_empty=0 → fifo_rd_data captured into the buffer at edge N+1 (inflight flag set for that cycle).
- fifo_rd_en is combinational: enable & (state==STREAM) & !fifo_empty & (count + inflight - pop < 2), where pop = out_valid & out_ready.
  - Guarantees no overflow and no rd_en while fifo_empty=1.
- Buffer: 2-entry FIFO, head drives out_data.
  - out_valid = (count != 0), registered.
  - Simultaneous capture and pop: count unchanged, order preserved.
- Stream rule: out_data/out_valid stay stable while out_valid=1 and out_ready=0.
- word_cnt increments by 1 per pop and wraps modulo 2^cnt_width.
- States:
  - IDLE: enable=1 → STREAM.
  - STREAM: enable=0 → DRAIN.
  - DRAIN: fifo_rd_en=0; once count==0 and inflight==0 → IDLE. enable=1 while in DRAIN → STREAM.
- Boundaries:
  - fifo_empty rising mid-stream → fetch stops; the in-flight word is still captured.
  - enable dropped with a read in flight → that word is still captured and delivered.
  - out_ready=0 indefinitely → at most 2 words pulled, then fifo_rd_en=0.
  - rst mid-transfer → all buffered and in-flight words discarded; no spurious out_valid after release.

Optional Feature:
- Macro: FIFO_RD_PARITY_EN.
- Defined: extra output out_parity (1 bit) = even parity (XOR) of the out_data bits, computed on capture and stored per buffer entry; 0 on reset.
- Undefined: port and storage absent; all other behaviour identical.

Test Plan:
- Reset, then FIFO preloaded with 0x11, enable=1, out_ready=1 → fifo_rd_en pulses once, out_data=0x11 with out_valid=1 for exactly 1 cycle, word_cnt=1, then back to fifo_rd_en=0.
- FIFO filled with 0..14, enable=1, out_ready=1 → 15 words delivered in order 0..14 on consecutive cycles after the first; no rd_en while fifo_empty=1; word_cnt=15.
- FIFO holds 0x55,0xEE,0xAA, out_ready=0 for 10 cycles → exactly 2 pops, out_data=0x55 held stable; out_ready=1 → 0x55,0xEE,0xAA delivered, no gaps or duplicates.
- Streaming 0..14, enable dropped after 5th pop → DRAIN, buffered and in-flight words delivered, no further rd_en, state returns to IDLE, busy=0, remaining words stay in the FIFO.
- rst=1 asserted with 2 words buffered → out_valid=0 and word_cnt=0 immediately (asynchronous); after release with FIFO empty, out_valid stays 0.
- With FIFO_RD_PARITY_EN defined: words 0xFF and 0x01 → out_parity=0 then 1.
